serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Parallel-in, serial-out framed transmitter; the sending end of the single-wire serial link whose
//  receive side samples the line with CK-edge flip-flops. Accepts one WIDTH-bit word per handshake,
//  shifts it out LSB first between a start bit (0) and a stop bit (1), each bit held DIV clocks.
//  Idle line level is 1.
// PARAMETERS
//  WIDTH  8  data bits per frame (>=1)
//  DIV    4  CK cycles per serial bit (>=1; DIV=1 legal, one bit per cycle)
// PORTS
//  CK     in   1      clock, all state changes on rising edge
//  RST_N  in   1      asynchronous, active-low reset
//  VALID  in   1      DIN holds a word to send
//  DIN    in   WIDTH  parallel data, sampled only on the accepting edge
//  READY  out  1      block can accept a word this cycle
//  SO     out  1      serial line output, registered
//  BUSY   out  1      frame in progress (= ~READY)
// BEHAVIOUR
//  - Reset (RST_N=0, async, no clock needed): SO=1, READY=1, BUSY=0, state IDLE, counters 0.
//    Reset mid-frame aborts the frame at once; SO returns to 1. No partial frame resumes.
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - Accept: rising edge with state IDLE and VALID=1. On that edge DIN loads into the shift
//    register, state->START, SO<=0, READY<=0, BUSY<=1. VALID while not IDLE is ignored.
//  - Bit timer counts 0..DIV-1; each bit lasts exactly DIV cycles, then the state/bit advances.
//  - DATA: SO = shreg[0]; shift right at each bit boundary; bit index 0..WIDTH-1, then next state.
//  - STOP: SO=1 for DIV cycles; at its end state->IDLE, READY<=1, BUSY<=0.
//  - Frame length (edge of acceptance to READY high) = (WIDTH+2)*DIV cycles (+DIV with parity).
//  - Back-to-back: VALID held high gives one IDLE cycle (SO=1, READY=1) between the stop bit and
//    the next start bit. Acceptance happens on that IDLE edge.
//  - DIN changes after the accepting edge have no effect on the frame in flight.
//  - Simultaneous RST_N low and accepting edge: reset wins; the word is not taken.
// CONFIGURATION
//  - SERIAL_TX_PARITY_EN defined: PARITY state follows DATA. SO = ^DIN_captured (even parity)
//    for DIV cycles. Frame = (WIDTH+3)*DIV cycles.
//  - Undefined: no PARITY state, no parity logic. DATA goes straight to STOP.
// STRUCTURE
//  - Package serial_pkg: state encoding constants (ST_IDLE, ST_START, ST_DATA, ST_PARITY,
//    ST_STOP), line levels IDLE_LVL=1, START_LVL=0, STOP_LVL=1. Shared with the receiver.
//  - Sub-module bit_timer (params DIV): counter with async active-low reset, clear input, and a
//    one-cycle TICK output on count DIV-1. serial_tx holds the FSM, shift register, bit index
//    and parity.
// TESTING (WIDTH=8, DIV=4 unless noted)
//  1 Reset: RST_N=0 at t=0 with no clock edge -> SO=1, READY=1, BUSY=0 immediately.
//  2 DIN=8'hA5, one-cycle VALID -> SO per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. READY high
//    40 cycles after the accepting edge.
//  3 VALID held, DIN=8'h00 then 8'hFF -> two frames with exactly one IDLE cycle between them.
//    DIN changed mid-frame does not alter the bits sent.
//  4 RST_N pulsed low during data bit 3 -> SO=1 and READY=1 asynchronously. Next VALID sends a
//    complete, correct frame.
//  5 DIV=1, DIN=8'h3C -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1.
//  6 With SERIAL_TX_PARITY_EN: DIN=8'hA5 -> parity bit 0; DIN=8'h01 -> parity bit 1.
//    Frame length is 44 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared encodings for the single-wire serial link: FSM state codes and line levels.
package serial_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter 0..DIV-1; tick_c marks the last cycle of each bit period.
module bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic ck,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == CNT_LAST);

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             so,
  output logic             busy
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             so_d, ready_d, busy_d;
  logic             tick_c;
  logic             timer_clr_c;
`ifdef SERIAL_TX_PARITY_EN
  logic             par, par_d;
`endif

  // Timer held at zero while idle so the start bit gets a full DIV cycles.
  assign timer_clr_c = (state == ST_IDLE);

  bit_timer #(.DIV(DIV)) u_bit_timer (
    .ck     (ck),
    .rst_n  (rst_n),
    .clr    (timer_clr_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      idx   <= '0;
      so    <= IDLE_LVL;
      ready <= 1'b1;
      busy  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      idx   <= idx_d;
      so    <= so_d;
      ready <= ready_d;
      busy  <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      par   <= par_d;
`endif
    end
  end

  // Next state plus next values of the registered line and handshake outputs.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    idx_d   = idx;
    so_d    = so;
    ready_d = ready;
    busy_d  = busy;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par;
`endif
    unique case (state)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_START;
          shreg_d = din;
          idx_d   = '0;
          so_d    = START_LVL;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_d = ST_DATA;
          so_d    = shreg[0];
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shreg_d = shreg >> 1;
          if (idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
            so_d    = par;
`else
            state_d = ST_STOP;
            so_d    = STOP_LVL;
`endif
          end else begin
            idx_d = idx + IDX_W'(1);
            so_d  = shreg_d[0];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) begin
          state_d = ST_STOP;
          so_d    = STOP_LVL;
        end
      end
`endif
      ST_STOP: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          so_d    = IDLE_LVL;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        so_d    = IDLE_LVL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a DIV=4 and a DIV=1 instance, each with its own line monitor.
module tb_serial_tx;

  localparam int unsigned WIDTH = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned NBITS  = WIDTH + 3;
  localparam int unsigned FRAME4 = 44;
`else
  localparam int unsigned NBITS  = WIDTH + 2;
  localparam int unsigned FRAME4 = 40;
`endif

  logic       ck;
  logic       rst_n;
  logic       valid4, ready4, so4, busy4;
  logic [7:0] din4;
  logic       valid1, ready1, so1, busy1;
  logic [7:0] din1;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q4[$];
  logic [7:0] exp_q1[$];

  serial_tx #(.WIDTH(WIDTH), .DIV(4)) u_dut4 (
    .ck(ck), .rst_n(rst_n), .valid(valid4), .din(din4),
    .ready(ready4), .so(so4), .busy(busy4)
  );

  serial_tx #(.WIDTH(WIDTH), .DIV(1)) u_dut1 (
    .ck(ck), .rst_n(rst_n), .valid(valid1), .din(din1),
    .ready(ready1), .so(so1), .busy(busy1)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Line bits in transmission order, index 0 leaves first.
  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] w);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {1'b1, w, 1'b0};
`endif
  endfunction

  function automatic logic mon_so(input int k);
    if (k == 0) return so4;
    return so1;
  endfunction

  function automatic logic mon_ready(input int k);
    if (k == 0) return ready4;
    return ready1;
  endfunction

  function automatic logic mon_busy(input int k);
    if (k == 0) return busy4;
    return busy1;
  endfunction

  function automatic int qsize(input int k);
    if (k == 0) return exp_q4.size();
    return exp_q1.size();
  endfunction

  // Watches one line; on a start bit pops the expected word and checks every bit period.
  task automatic monitor(input int k, input int div);
    logic [NBITS-1:0] bits;
    logic [7:0]       w;
    logic             got_bit;
    bit               aborted;
    bit               hs_ok;
    forever begin
      @(negedge ck);
      if (rst_n && !mon_so(k) && mon_busy(k)) begin
        if (qsize(k) == 0) begin
          check($sformatf("dut%0d_unexpected_frame", k), 32'd1, 32'd0);
        end else begin
          if (k == 0) w = exp_q4.pop_front();
          else        w = exp_q1.pop_front();
          bits    = frame_bits(w);
          aborted = 1'b0;
          hs_ok   = 1'b1;
          for (int b = 0; b < int'(NBITS) && !aborted; b++) begin
            got_bit = bits[b];
            for (int c = 0; c < div && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge ck);
              if (!rst_n) begin
                aborted = 1'b1;
              end else begin
                if (mon_so(k) !== bits[b]) got_bit = mon_so(k);
                if (mon_ready(k) !== 1'b0 || mon_busy(k) !== 1'b1) hs_ok = 1'b0;
              end
            end
            if (!aborted)
              check($sformatf("dut%0d_w%02h_bit%0d", k, w, b), 32'(got_bit), 32'(bits[b]));
          end
          if (!aborted) begin
            check($sformatf("dut%0d_w%02h_busy_in_frame", k, w), 32'(hs_ok), 32'd1);
            @(negedge ck);
            if (rst_n) begin
              check($sformatf("dut%0d_w%02h_ready_at_end", k, w), 32'(mon_ready(k)), 32'd1);
              check($sformatf("dut%0d_w%02h_idle_line", k, w), 32'(mon_so(k)), 32'd1);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0, 4);
  initial monitor(1, 1);

  task automatic send(input int k, input logic [7:0] w);
    int t = 0;
    @(negedge ck);
    if (k == 0) begin din4 = w; valid4 = 1'b1; end
    else        begin din1 = w; valid1 = 1'b1; end
    while (!mon_ready(k) && t < 200) begin @(negedge ck); t++; end
    check($sformatf("dut%0d_send_ready", k), 32'(mon_ready(k)), 32'd1);
    if (mon_ready(k)) begin
      if (k == 0) exp_q4.push_back(w);
      else        exp_q1.push_back(w);
    end
    @(posedge ck);
    #1;
    if (k == 0) valid4 = 1'b0;
    else        valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while (t < 400 && !(mon_ready(k) && qsize(k) == 0)) begin @(negedge ck); t++; end
    check($sformatf("dut%0d_idle_reached", k), 32'(mon_ready(k) && qsize(k) == 0), 32'd1);
    repeat (2) @(negedge ck);
  endtask

  initial begin
    int cyc;
    int gap;
    rst_n  = 1'b1;
    valid4 = 1'b0;
    valid1 = 1'b0;
    din4   = 8'h00;
    din1   = 8'h00;

    // Reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    check("rst_so4", 32'(so4), 32'd1);
    check("rst_ready4", 32'(ready4), 32'd1);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_so1", 32'(so1), 32'd1);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;

    // Single A5 frame with one-cycle VALID; measure frame length.
    @(negedge ck);
    din4 = 8'hA5; valid4 = 1'b1;
    exp_q4.push_back(8'hA5);
    @(posedge ck);
    #1 valid4 = 1'b0;
    din4 = 8'h3C;
    check("accept_ready_low", 32'(ready4), 32'd0);
    check("accept_start_bit", 32'(so4), 32'd0);
    cyc = 0;
    while (!ready4 && cyc < 200) begin @(posedge ck); #1; cyc++; end
    check("frame_len_A5", 32'(cyc), 32'(FRAME4));
    wait_idle(0);

    // Back-to-back with VALID held; DIN changes mid-frame.
    @(negedge ck);
    din4 = 8'h00; valid4 = 1'b1;
    exp_q4.push_back(8'h00);
    @(negedge ck);
    din4 = 8'hFF;
    exp_q4.push_back(8'hFF);
    cyc = 0;
    while (!ready4 && cyc < 200) begin @(negedge ck); cyc++; end
    gap = 0;
    while (ready4 && gap < 10) begin gap++; @(negedge ck); end
    check("b2b_idle_gap", 32'(gap), 32'd1);
    din4 = 8'h5A; valid4 = 1'b0;
    wait_idle(0);

    // Reset pulse during data bit 3, then a clean frame.
    @(negedge ck);
    din4 = 8'hA5; valid4 = 1'b1;
    exp_q4.push_back(8'hA5);
    @(posedge ck);
    #1 valid4 = 1'b0;
    repeat (16) @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_so", 32'(so4), 32'd1);
    check("midrst_ready", 32'(ready4), 32'd1);
    check("midrst_busy", 32'(busy4), 32'd0);
    @(negedge ck);
    @(posedge ck);
    #2 rst_n = 1'b1;
    send(0, 8'hC3);
    wait_idle(0);

    // DIV=1 instance, including back-to-back words.
    send(1, 8'h3C);
    send(1, 8'h81);
    wait_idle(1);

    // Parity-sensitive words (plain frames when parity is off).
    send(0, 8'h01);
    wait_idle(0);
    send(0, 8'hA5);
    wait_idle(0);

    check("q4_drained", 32'(exp_q4.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
